ps2_kb_event_fifo: RTL and testbench

Parametrised successor to the current keyboard front end. It receives PS/2 device-to-host frames on `ps2c`/`ps2d` and validates start, odd parity and stop bits. It decodes the `E0` (extended) and `F0` (break) prefixes into tagged key events and queues them in a configurable-depth show-ahead FIFO, with overflow and frame-error reporting. It sits between the PS/2 pins and game/control logic (LED debug, maze movement) and replaces the fixed-depth, make/break-agnostic code buffer.

---
 rtl/ps2_kb_event_fifo_if.sv | 22 ++
 rtl/ps2_kb_event_fifo.sv | 211 +++++++++++++++++++++
 tb/tb_ps2_kb_event_fifo.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_kb_event_fifo_if.sv
// Key-event read port of the PS/2 keyboard front end.
// The master side is the FIFO; the slave side is the consumer that pops events.
interface ps2_kb_event_fifo_if;
    logic       rd_key_code;
    logic [7:0] key_code;
    logic       key_break;
    logic       key_ext;
    logic       kb_buf_empty;
    logic       kb_buf_full;
    logic       overflow;
    logic       frame_err;

    modport master (
        input  rd_key_code,
        output key_code, key_break, key_ext, kb_buf_empty, kb_buf_full, overflow, frame_err
    );

    modport slave (
        output rd_key_code,
        input  key_code, key_break, key_ext, kb_buf_empty, kb_buf_full, overflow, frame_err
    );
endinterface

// File: rtl/ps2_kb_event_fifo.sv
// PS/2 keyboard receiver: filtered frame capture, E0/F0 prefix decode into tagged
// key events, and a show-ahead event FIFO with overflow and frame-error reporting.
module ps2_kb_event_fifo #(
    parameter int unsigned FIFO_ADDR_W = 2,
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int unsigned REPORT_MAKE = 1
) (
    input  logic clk,
    input  logic reset,
    inout  wire  ps2d,
    inout  wire  ps2c,
    ps2_kb_event_fifo_if.master kb
);
    localparam int unsigned DEPTH = 2 ** FIFO_ADDR_W;
    localparam int unsigned CNT_W = FIFO_ADDR_W + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned EVT_W = 10;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_CHECK} rx_state_e;

    logic [1:0]            c_sync_q, c_sync_d, d_sync_q, d_sync_d;
    logic [FILTER_LEN-1:0] hist_q, hist_d;
    logic                  fc_q, fc_d, fall_q, fall_d;

    rx_state_e             state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [9:0]            sh_q, sh_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  frame_err_q, frame_err_d;
    logic                  rx_byte_q, rx_byte_d;
    logic [7:0]            rx_data_q, rx_data_d;

    logic                  ext_q, ext_d, brk_q, brk_d;
    logic                  push_c;
    logic [EVT_W-1:0]      entry_c;

    logic [EVT_W-1:0]      mem_q [DEPTH];
    logic [EVT_W-1:0]      mem_d [DEPTH];
    logic [FIFO_ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic [EVT_W-1:0]      head_q, head_d;
    logic                  empty_q, empty_d, full_q, full_d;
    logic                  pop_c, wr_c, is_full_c;

    // Pin synchronisers and ps2c glitch filter; fc only moves on a unanimous history
    always_comb begin
        c_sync_d = {c_sync_q[0], ps2c};
        d_sync_d = {d_sync_q[0], ps2d};
        hist_d   = {hist_q[FILTER_LEN-2:0], c_sync_q[1]};
        fc_d     = fc_q;
        if (&hist_q) begin
            fc_d = 1'b1;
        end else if (~|hist_q) begin
            fc_d = 1'b0;
        end
        fall_d = fc_q & ~fc_d;
    end

    // Frame receiver: start bit, 8 data bits LSB first, odd parity, stop bit
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sh_d        = sh_q;
        tmo_d       = tmo_q;
        frame_err_d = 1'b0;
        rx_byte_d   = 1'b0;
        rx_data_d   = rx_data_q;
        case (state_q)
            ST_IDLE: begin
                if (fall_q) begin
                    if (!d_sync_q[1]) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                        tmo_d     = '0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (fall_q) begin
                    sh_d      = {d_sync_q[1], sh_q[9:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    tmo_d     = '0;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = ST_CHECK;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if ((^sh_q[8:0]) && sh_q[9]) begin
                    rx_byte_d = 1'b1;
                    rx_data_d = sh_q[7:0];
                end else begin
                    frame_err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Prefix decoder: E0/F0 accumulate until a plain code byte forms an event
    always_comb begin
        ext_d   = ext_q;
        brk_d   = brk_q;
        push_c  = 1'b0;
        entry_c = {ext_q, brk_q, rx_data_q};
        if (rx_byte_q) begin
            if (rx_data_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (rx_data_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                push_c = brk_q || (REPORT_MAKE != 0);
                ext_d  = 1'b0;
                brk_d  = 1'b0;
            end
        end
    end

    // Event FIFO; head outputs are registered from the post-update state
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ovf_d     = ovf_q;
        is_full_c = (cnt_q == CNT_W'(DEPTH));
        pop_c     = kb.rd_key_code && (cnt_q != '0);
        wr_c      = push_c && (!is_full_c || pop_c);
        if (wr_c) begin
            mem_d[wr_ptr_q] = entry_c;
            wr_ptr_d        = wr_ptr_q + FIFO_ADDR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + FIFO_ADDR_W'(1);
        end
        if (push_c && is_full_c && !pop_c) begin
            ovf_d = 1'b1;
        end
        cnt_d   = cnt_q + CNT_W'(wr_c) - CNT_W'(pop_c);
        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == CNT_W'(DEPTH));
        head_d  = empty_d ? '0 : mem_d[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            c_sync_q    <= 2'b11;
            d_sync_q    <= 2'b11;
            hist_q      <= '1;
            fc_q        <= 1'b1;
            fall_q      <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            sh_q        <= '0;
            tmo_q       <= '0;
            frame_err_q <= 1'b0;
            rx_byte_q   <= 1'b0;
            rx_data_q   <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            head_q      <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
        end else begin
            c_sync_q    <= c_sync_d;
            d_sync_q    <= d_sync_d;
            hist_q      <= hist_d;
            fc_q        <= fc_d;
            fall_q      <= fall_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_q        <= sh_d;
            tmo_q       <= tmo_d;
            frame_err_q <= frame_err_d;
            rx_byte_q   <= rx_byte_d;
            rx_data_q   <= rx_data_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            head_q      <= head_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
        end
    end

    assign kb.key_code     = head_q[7:0];
    assign kb.key_break    = head_q[8];
    assign kb.key_ext      = head_q[9];
    assign kb.kb_buf_empty = empty_q;
    assign kb.kb_buf_full  = full_q;
    assign kb.overflow     = ovf_q;
    assign kb.frame_err    = frame_err_q;
endmodule

// File: tb/tb_ps2_kb_event_fifo.sv
// Bench for ps2_kb_event_fifo: two instances (make+break and break-only) share the
// PS/2 pins; events are predicted by a queue model of the scan-code protocol.
module tb_ps2_kb_event_fifo;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned FILT   = 8;
    localparam int unsigned TMO    = 400;
    localparam int          HALF   = 20;

    logic clk = 1'b0;
    logic reset;
    logic ps2c_drv, ps2d_drv;
    wire  ps2c, ps2d;
    assign ps2c = ps2c_drv;
    assign ps2d = ps2d_drv;

    ps2_kb_event_fifo_if ifa ();
    ps2_kb_event_fifo_if ifb ();

    ps2_kb_event_fifo #(.FIFO_ADDR_W(ADDR_W), .FILTER_LEN(FILT), .TIMEOUT_CYC(TMO), .REPORT_MAKE(1))
        u_dut_a (.clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .kb(ifa));
    ps2_kb_event_fifo #(.FIFO_ADDR_W(ADDR_W), .FILTER_LEN(FILT), .TIMEOUT_CYC(TMO), .REPORT_MAKE(0))
        u_dut_b (.clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .kb(ifb));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fe_a = 0;
    int fe_b = 0;
    int last_fall_cyc = 0;

    logic [9:0]  mq_a[$];
    logic [9:0]  mq_b[$];
    bit          m_ext, m_brk, movf_a, movf_b;
    bit          dip;
    logic [10:0] pop_head;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ifa.frame_err === 1'b1) fe_a <= fe_a + 1;
        if (ifb.frame_err === 1'b1) fe_b <= fe_b + 1;
    end

    // ---------------- reference model ----------------
    task automatic model_clear();
        mq_a.delete();
        mq_b.delete();
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        movf_a = 1'b0;
        movf_b = 1'b0;
    endtask

    task automatic model_rx(input logic [7:0] b);
        logic [9:0] ev;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            ev = {m_ext, m_brk, b};
            if (mq_a.size() >= DEPTH) movf_a = 1'b1; else mq_a.push_back(ev);
            if (m_brk) begin
                if (mq_b.size() >= DEPTH) movf_b = 1'b1; else mq_b.push_back(ev);
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    function automatic logic [10:0] model_pop(input int which);
        logic [10:0] r;
        r = 11'h400;
        if (which == 0 && mq_a.size() > 0) r = {1'b0, mq_a.pop_front()};
        if (which == 1 && mq_b.size() > 0) r = {1'b0, mq_b.pop_front()};
        return r;
    endfunction

    function automatic logic [7:0] rand_code();
        logic [7:0] c;
        do c = 8'($urandom_range(0, 255)); while (c == 8'hE0 || c == 8'hF0);
        return c;
    endfunction

    // ---------------- stimulus ----------------
    task automatic ps2_bit(input logic b, input bit glitch, input int pop_at);
        ps2d_drv = b;
        for (int i = 0; i < HALF; i++) begin
            if (glitch) ps2c_drv = (i == HALF / 2) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        ps2c_drv = 1'b1;
        ps2c_drv = 1'b0;
        last_fall_cyc = cyc;
        for (int i = 0; i < HALF; i++) begin
            if (pop_at >= 0 && ifa.kb_buf_full !== 1'b1) dip = 1'b1;
            if (i == pop_at) pop_head = {ifa.kb_buf_empty, ifa.key_ext, ifa.key_break, ifa.key_code};
            ifa.rd_key_code = (i == pop_at);
            @(negedge clk);
        end
        ifa.rd_key_code = 1'b0;
        ps2c_drv = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_start, input bit bad_par,
                              input bit bad_stop, input int glitch_bit, input int pop_at, input int nbits);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, bad_start};
        for (int i = 0; i < nbits; i++) ps2_bit(bits[i], i == glitch_bit, (i == 10) ? pop_at : -1);
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 1'b0, -1, -1, 11);
        model_rx(b);
    endtask

    task automatic pop_one(input int which, output logic [10:0] got);
        if (which == 0) begin
            got = {ifa.kb_buf_empty, ifa.key_ext, ifa.key_break, ifa.key_code};
            ifa.rd_key_code = 1'b1;
        end else begin
            got = {ifb.kb_buf_empty, ifb.key_ext, ifb.key_break, ifb.key_code};
            ifb.rd_key_code = 1'b1;
        end
        @(negedge clk);
        ifa.rd_key_code = 1'b0;
        ifb.rd_key_code = 1'b0;
    endtask

    task automatic do_reset();
        ps2c_drv = 1'b1;
        ps2d_drv = 1'b1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_clear();
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [10:0] got, exp;
        int fe0a, na, nb;
        ps2c_drv = 1'b1; ps2d_drv = 1'b1;
        ifa.rd_key_code = 1'b0; ifb.rd_key_code = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        model_clear();
        @(negedge clk);
        checks++;
        if ({ifa.kb_buf_empty, ifa.kb_buf_full, ifa.overflow, ifa.frame_err, ifa.key_ext, ifa.key_break, ifa.key_code} !== {1'b1, 13'h0}) begin
            failures++; $display("FAIL reset_a: got %b expected 10000000000000", {ifa.kb_buf_empty, ifa.kb_buf_full, ifa.overflow, ifa.frame_err, ifa.key_ext, ifa.key_break, ifa.key_code});
        end
        checks++;
        if ({ifb.kb_buf_empty, ifb.kb_buf_full, ifb.overflow, ifb.frame_err, ifb.key_ext, ifb.key_break, ifb.key_code} !== {1'b1, 13'h0}) begin
            failures++; $display("FAIL reset_b: got %b expected 10000000000000", {ifb.kb_buf_empty, ifb.kb_buf_full, ifb.overflow, ifb.frame_err, ifb.key_ext, ifb.key_break, ifb.key_code});
        end
        send_byte(8'h1C);
        send_byte(8'hF0);
        fe0a = fe_a;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, -1, -1, 5);
        do_reset();
        checks++;
        if ({ifa.kb_buf_empty, ifa.kb_buf_full, ifa.overflow, ifa.frame_err, ifa.key_ext, ifa.key_break, ifa.key_code} !== {1'b1, 13'h0}) begin
            failures++; $display("FAIL midreset_a: got %b expected 10000000000000", {ifa.kb_buf_empty, ifa.kb_buf_full, ifa.overflow, ifa.frame_err, ifa.key_ext, ifa.key_break, ifa.key_code});
        end
        send_byte(8'h1C);
        repeat (4) @(negedge clk);
        checks++;
        if (fe_a !== fe0a) begin failures++; $display("FAIL midreset_ferr: got %0d pulses expected 0", fe_a - fe0a); end
        na = mq_a.size(); nb = mq_b.size();
        for (int i = 0; i <= na; i++) begin
            exp = model_pop(0); pop_one(0, got); checks++;
            if (got !== exp) begin failures++; $display("FAIL reset_drain_a[%0d]: got %h expected %h", i, got, exp); end
        end
        for (int i = 0; i <= nb; i++) begin
            exp = model_pop(1); pop_one(1, got); checks++;
            if (got !== exp) begin failures++; $display("FAIL reset_drain_b[%0d]: got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_make_break();
        logic [10:0] got, exp;
        int na, nb;
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        na = mq_a.size(); nb = mq_b.size();
        for (int i = 0; i <= na; i++) begin
            exp = model_pop(0); pop_one(0, got); checks++;
            if (got !== exp) begin failures++; $display("FAIL mb_drain_a[%0d]: got %h expected %h", i, got, exp); end
        end
        for (int i = 0; i <= nb; i++) begin
            exp = model_pop(1); pop_one(1, got); checks++;
            if (got !== exp) begin failures++; $display("FAIL mb_drain_b[%0d]: got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_extended();
        logic [10:0] got, exp;
        int na, nb;
        send_byte(8'hE0);
        send_byte(8'h75);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        na = mq_a.size(); nb = mq_b.size();
        for (int i = 0; i <= na; i++) begin
            exp = model_pop(0); pop_one(0, got); checks++;
            if (got !== exp) begin failures++; $display("FAIL ext_drain_a[%0d]: got %h expected %h", i, got, exp); end
        end
        for (int i = 0; i <= nb; i++) begin
            exp = model_pop(1); pop_one(1, got); checks++;
            if (got !== exp) begin failures++; $display("FAIL ext_drain_b[%0d]: got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_errors();
        logic [10:0] got, exp;
        int fe0a, fe0b, t_err, dt, na;
        fe0a = fe_a; fe0b = fe_b;
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, -1, -1, 11);
        checks++;
        if (fe_a - fe0a != 1 || fe_b - fe0b != 1 || ifa.kb_buf_empty !== 1'b1) begin
            failures++; $display("FAIL parity_err: pulses a=%0d b=%0d empty=%b expected 1 1 1", fe_a - fe0a, fe_b - fe0b, ifa.kb_buf_empty);
        end
        fe0a = fe_a;
        send_frame(8'h1C, 1'b0, 1'b0, 1'b1, -1, -1, 11);
        checks++;
        if (fe_a - fe0a != 1 || ifa.kb_buf_empty !== 1'b1) begin
            failures++; $display("FAIL stop_err: pulses=%0d empty=%b expected 1 1", fe_a - fe0a, ifa.kb_buf_empty);
        end
        fe0a = fe_a;
        send_frame(8'h00, 1'b1, 1'b0, 1'b0, -1, -1, 1);
        checks++;
        if (fe_a - fe0a != 1) begin failures++; $display("FAIL start_err: pulses=%0d expected 1", fe_a - fe0a); end
        fe0a = fe_a; fe0b = fe_b;
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0, -1, -1, 4);
        t_err = -1;
        for (int i = 0; i < int'(TMO) + 200; i++) begin
            @(negedge clk);
            if (ifa.frame_err === 1'b1) begin t_err = cyc; break; end
        end
        dt = t_err - last_fall_cyc;
        checks++;
        if (t_err < 0 || dt < int'(TMO) || dt > int'(TMO + FILT) + 12) begin
            failures++; $display("FAIL timeout_delay: got %0d cycles (t_err=%0d) expected %0d..%0d", dt, t_err, TMO, TMO + FILT + 12);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (fe_a - fe0a != 1 || fe_b - fe0b != 1) begin
            failures++; $display("FAIL timeout_pulse: pulses a=%0d b=%0d expected 1 1", fe_a - fe0a, fe_b - fe0b);
        end
        fe0a = fe_a;
        send_frame(8'h2C, 1'b0, 1'b0, 1'b0, 3, -1, 11);
        model_rx(8'h2C);
        checks++;
        if (fe_a != fe0a) begin failures++; $display("FAIL glitch_ferr: pulses=%0d expected 0", fe_a - fe0a); end
        na = mq_a.size();
        for (int i = 0; i <= na; i++) begin
            exp = model_pop(0); pop_one(0, got); checks++;
            if (got !== exp) begin failures++; $display("FAIL glitch_drain_a[%0d]: got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] got, exp;
        logic [7:0]  code;
        bit          found;
        int          na;
        do_reset();
        for (int i = 0; i < int'(DEPTH); i++) send_byte(rand_code());
        checks++;
        if (ifa.kb_buf_full !== 1'b1 || ifa.overflow !== 1'b0) begin
            failures++; $display("FAIL b2b_fill: full=%b ovf=%b expected 1 0", ifa.kb_buf_full, ifa.overflow);
        end
        found = 1'b0;
        for (int k = 0; k < HALF - 1 && !found; k++) begin
            code = rand_code();
            exp  = model_pop(0);
            dip  = 1'b0;
            send_frame(code, 1'b0, 1'b0, 1'b0, -1, k, 11);
            model_rx(code);
            checks++;
            if (pop_head !== exp) begin failures++; $display("FAIL b2b_pop[k=%0d]: got %h expected %h", k, pop_head, exp); end
            checks++;
            if (ifa.kb_buf_full !== 1'b1 || ifa.overflow !== 1'b0) begin
                failures++; $display("FAIL b2b_state[k=%0d]: full=%b ovf=%b expected 1 0", k, ifa.kb_buf_full, ifa.overflow);
            end
            if (!dip) found = 1'b1;
        end
        checks++;
        if (!found) begin failures++; $display("FAIL b2b_simultaneous: got full dip in every trial expected one trial with full held"); end
        na = mq_a.size();
        for (int i = 0; i <= na; i++) begin
            exp = model_pop(0); pop_one(0, got); checks++;
            if (got !== exp) begin failures++; $display("FAIL b2b_drain_a[%0d]: got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_overflow();
        logic [10:0] got, exp;
        logic [7:0]  codes [5];
        int          na;
        codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        do_reset();
        foreach (codes[i]) send_byte(codes[i]);
        checks++;
        if (ifa.kb_buf_full !== 1'b1 || ifa.overflow !== movf_a || ifb.overflow !== movf_b) begin
            failures++; $display("FAIL ovf_flags: full=%b ovf_a=%b ovf_b=%b expected 1 %b %b", ifa.kb_buf_full, ifa.overflow, ifb.overflow, movf_a, movf_b);
        end
        na = mq_a.size();
        for (int i = 0; i <= na; i++) begin
            exp = model_pop(0); pop_one(0, got); checks++;
            if (got !== exp) begin failures++; $display("FAIL ovf_drain_a[%0d]: got %h expected %h", i, got, exp); end
        end
        checks++;
        if (ifa.overflow !== movf_a || ifa.kb_buf_full !== 1'b0) begin
            failures++; $display("FAIL ovf_sticky: ovf=%b full=%b expected %b 0", ifa.overflow, ifa.kb_buf_full, movf_a);
        end
    endtask

    task automatic test_random();
        logic [10:0] got, exp;
        logic [1:0]  r;
        int          na, nb;
        do_reset();
        for (int ev = 0; ev < 15; ev++) begin
            r = 2'($urandom_range(0, 3));
            if (r[0]) send_byte(8'hE0);
            if (r[1]) send_byte(8'hF0);
            send_byte(rand_code());
            if (ev % 3 == 2 || ev == 14) begin
                na = mq_a.size(); nb = mq_b.size();
                for (int i = 0; i <= na; i++) begin
                    exp = model_pop(0); pop_one(0, got); checks++;
                    if (got !== exp) begin failures++; $display("FAIL rnd_drain_a[%0d.%0d]: got %h expected %h", ev, i, got, exp); end
                end
                for (int i = 0; i <= nb; i++) begin
                    exp = model_pop(1); pop_one(1, got); checks++;
                    if (got !== exp) begin failures++; $display("FAIL rnd_drain_b[%0d.%0d]: got %h expected %h", ev, i, got, exp); end
                end
                checks++;
                if (ifa.overflow !== movf_a || ifb.overflow !== movf_b) begin
                    failures++; $display("FAIL rnd_ovf[%0d]: got %b %b expected %b %b", ev, ifa.overflow, ifb.overflow, movf_a, movf_b);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_extended();
        test_errors();
        test_back_to_back();
        test_overflow();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end
endmodule
